// File: rtl/signal_debouncer_pkg.sv
// Shared types and defaults for the signal debouncer.
package signal_debouncer_pkg;

    // 1 ms at a 100 MHz clock.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;

    typedef enum logic [1:0] {
        StableLow  = 2'd0,
        WaitHigh   = 2'd1,
        StableHigh = 2'd2,
        WaitLow    = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes effect before the increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count;
        if (clr) begin
            count_d = '0;
        end
        if (inc && (count_d != '1)) begin
            count_d = count_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/signal_debouncer.sv
// Debounces a synchronized level: registered clean level, edge strobes and a glitch counter.
module signal_debouncer
    import signal_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          RESET_LEVEL     = 1'b0,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sig_in,
    input  logic                glitch_clr,
    output logic                sig_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             sig_out_d, rise_d, fall_d, abort;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sig_out_d = sig_out;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        abort     = 1'b0;
        unique case (state)
            StableLow: begin
                cnt_d = '0;
                if (sig_in) begin
                    state_d = WaitHigh;
                    cnt_d   = CNT_W'(1);
                end
            end
            WaitHigh: begin
                if (!sig_in) begin
                    state_d = StableLow;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_d   = StableHigh;
                    cnt_d     = '0;
                    sig_out_d = 1'b1;
                    rise_d    = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            StableHigh: begin
                cnt_d = '0;
                if (!sig_in) begin
                    state_d = WaitLow;
                    cnt_d   = CNT_W'(1);
                end
            end
            WaitLow: begin
                if (sig_in) begin
                    state_d = StableHigh;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_d   = StableLow;
                    cnt_d     = '0;
                    sig_out_d = 1'b0;
                    fall_d    = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RESET_LEVEL ? StableHigh : StableLow;
            cnt        <= '0;
            sig_out    <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sig_out    <= sig_out_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
        end
    end

    sat_counter #(
        .WIDTH (GLITCH_W)
    ) u_glitch_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (glitch_clr),
        .inc   (abort),
        .count (glitch_count)
    );

endmodule

// File: tb/tb_signal_debouncer.sv
// Self-checking bench: DEBOUNCE_CYCLES=4, GLITCH_W=3, one instance per RESET_LEVEL.
module tb_signal_debouncer;

    typedef struct {
        string      name;
        bit         sel;
        logic       rst;
        logic       din;
        logic       clr;
        logic       out;
        logic       rise;
        logic       fall;
        logic [2:0] gc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, din_a = 1'b0, clr_a = 1'b0;
    logic       rst_b = 1'b1, din_b = 1'b1, clr_b = 1'b0;
    logic       out_a, rise_a, fall_a, out_b, rise_b, fall_b;
    logic [2:0] gc_a, gc_b;

    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    vec_t expq[$];

    always #5 clk = ~clk;

    signal_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (1'b0),
        .GLITCH_W        (3)
    ) dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .sig_in       (din_a),
        .glitch_clr   (clr_a),
        .sig_out      (out_a),
        .rise_pulse   (rise_a),
        .fall_pulse   (fall_a),
        .glitch_count (gc_a)
    );

    signal_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (1'b1),
        .GLITCH_W        (3)
    ) dut_b (
        .clk          (clk),
        .reset        (rst_b),
        .sig_in       (din_b),
        .glitch_clr   (clr_b),
        .sig_out      (out_b),
        .rise_pulse   (rise_b),
        .fall_pulse   (fall_b),
        .glitch_count (gc_b)
    );

    function automatic vec_t mk(string name, bit sel, logic r, logic d, logic c,
                                logic o, logic ri, logic fa, logic [2:0] g);
        vec_t v;
        v.name = name; v.sel = sel; v.rst = r; v.din = d; v.clr = c;
        v.out = o; v.rise = ri; v.fall = fa; v.gc = g;
        return v;
    endfunction

    function automatic void add(int n, string name, logic r, logic d, logic c,
                                logic o, logic ri, logic fa, logic [2:0] g);
        for (int i = 0; i < n; i++) tbl.push_back(mk(name, 1'b0, r, d, c, o, ri, fa, g));
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        vec_t       e;
        logic       o, ri, fa;
        logic [2:0] g;
        expq.push_back(v);
        if (!v.sel) begin
            rst_a = v.rst; din_a = v.din; clr_a = v.clr;
        end else begin
            rst_b = v.rst; din_b = v.din; clr_b = v.clr;
        end
        @(posedge clk);
        #1;
        e = expq.pop_front();
        if (!e.sel) begin
            o = out_a; ri = rise_a; fa = fall_a; g = gc_a;
        end else begin
            o = out_b; ri = rise_b; fa = fall_b; g = gc_b;
        end
        checks++;
        if (o !== e.out || ri !== e.rise || fa !== e.fall || g !== e.gc) begin
            failures++;
            $display("FAIL %s (check %0d): got out=%b rise=%b fall=%b glitch=%0d, want out=%b rise=%b fall=%b glitch=%0d",
                     e.name, checks, o, ri, fa, g, e.out, e.rise, e.fall, e.gc);
        end
    endtask

    task automatic hs(input bit sel, input string name, input logic r, input logic d,
                      input logic c, input logic o, input logic ri, input logic fa,
                      input logic [2:0] g);
        apply(mk(name, sel, r, d, c, o, ri, fa, g));
    endtask

    initial begin
        int g;

        //   n   name          rst din clr out rise fall gc
        add(2,  "reset",       1,  0,  0,  0,  0,   0,   0);
        add(3,  "rise_wait",   0,  1,  0,  0,  0,   0,   0);
        add(1,  "rise_edge",   0,  1,  0,  1,  1,   0,   0);
        add(6,  "rise_hold",   0,  1,  0,  1,  0,   0,   0);
        add(3,  "fall_wait",   0,  0,  0,  1,  0,   0,   0);
        add(1,  "fall_edge",   0,  0,  0,  0,  0,   1,   0);
        add(2,  "fall_hold",   0,  0,  0,  0,  0,   0,   0);
        for (int k = 1; k <= 3; k++) begin
            add(3, "bounce_hi",  0, 1, 0, 0, 0, 0, 3'(k - 1));
            add(1, "bounce_ab",  0, 0, 0, 0, 0, 0, 3'(k));
        end
        add(3,  "bounce_low",  0,  0,  0,  0,  0,   0,   3);
        add(1,  "clr_pulse",   0,  0,  1,  0,  0,   0,   0);
        add(1,  "clr_release", 0,  0,  0,  0,  0,   0,   0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Saturation: nine aborted two-sample glitches.
        for (int i = 0; i < 9; i++) begin
            g = (i > 7) ? 7 : i;
            hs(0, "sat_hi", 0, 1, 0, 0, 0, 0, 3'(g));
            hs(0, "sat_hi", 0, 1, 0, 0, 0, 0, 3'(g));
            g = (i + 1 > 7) ? 7 : i + 1;
            hs(0, "sat_abort", 0, 0, 0, 0, 0, 0, 3'(g));
        end
        hs(0, "sat_clr", 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 2; i++) begin
            hs(0, "pre_hi", 0, 1, 0, 0, 0, 0, 3'(i - 1));
            hs(0, "pre_ab", 0, 0, 0, 0, 0, 0, 3'(i));
        end
        hs(0, "clr_ab_hi", 0, 1, 0, 0, 0, 0, 2);
        hs(0, "clr_ab_hi", 0, 1, 0, 0, 0, 0, 2);
        hs(0, "clr_and_ab", 0, 0, 1, 0, 0, 0, 1);

        // Reset in the middle of a rising wait.
        for (int i = 0; i < 3; i++) hs(0, "rst_wait", 0, 1, 0, 0, 0, 0, 1);
        hs(0, "rst_mid", 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) hs(0, "rst_restart", 0, 1, 0, 0, 0, 0, 0);
        hs(0, "rst_rise", 0, 1, 0, 1, 1, 0, 0);
        hs(0, "rst_after", 0, 1, 0, 1, 0, 0, 0);

        // RESET_LEVEL=1 instance.
        hs(1, "hi_reset", 1, 1, 0, 1, 0, 0, 0);
        hs(1, "hi_reset", 1, 1, 0, 1, 0, 0, 0);
        hs(1, "hi_idle", 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) hs(1, "hi_short_lo", 0, 0, 0, 1, 0, 0, 0);
        hs(1, "hi_short_ab", 0, 1, 0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) hs(1, "hi_long_lo", 0, 0, 0, 1, 0, 0, 1);
        hs(1, "hi_fall", 0, 0, 0, 0, 0, 1, 1);
        hs(1, "hi_after", 0, 0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
